alu_result_stage: RTL and testbench

- Registered stage directly downstream of the arithmetic core.
- Captures the core's result, carry and overflow, plus the 3-bit op code, through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Derives the zero and negative flags.
- Commits each entry on pop to an architectural accumulator and status register; CMP updates flags only.

---
 rtl/alu_result_stage.sv | 150 +++++++++++++++
 tb/tb_alu_result_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered result stage: 2-entry skid buffer, flag derivation,
// accumulator/status commit on pop and sticky invalid-op error.
module alu_result_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_is_cmp,
  output logic [WIDTH-1:0] acc,
  output logic [3:0]       status,
  output logic             err,
  input  logic             clr_err
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] head_result_q, head_result_d;
  logic [3:0]       head_flags_q, head_flags_d;
  logic             head_cmp_q, head_cmp_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic [3:0]       skid_flags_q, skid_flags_d;
  logic             skid_cmp_q, skid_cmp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       status_q, status_d;
  logic             err_q, err_d;

  logic             accept, op_legal, push, bad_op, pop;
  logic [3:0]       new_flags;
  logic             new_cmp;

  // Invalid ops are consumed by the handshake but never enter the buffer.
  assign op_legal  = (in_op <= 3'd4);
  assign accept    = in_valid && in_ready_q;
  assign push      = accept && op_legal;
  assign bad_op    = accept && !op_legal;
  assign pop       = out_valid_q && out_ready;
  assign new_flags = {in_result[WIDTH-1], (in_result == '0), in_overflow, in_carry};
  assign new_cmp   = (in_op == 3'd4);

  always_comb begin
    state_d       = state_q;
    head_result_d = head_result_q;
    head_flags_d  = head_flags_q;
    head_cmp_d    = head_cmp_q;
    skid_result_d = skid_result_q;
    skid_flags_d  = skid_flags_q;
    skid_cmp_d    = skid_cmp_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d       = ONE;
          head_result_d = in_result;
          head_flags_d  = new_flags;
          head_cmp_d    = new_cmp;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_result_d = in_result;
          head_flags_d  = new_flags;
          head_cmp_d    = new_cmp;
        end else if (push) begin
          state_d       = TWO;
          skid_result_d = in_result;
          skid_flags_d  = new_flags;
          skid_cmp_d    = new_cmp;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d       = ONE;
          head_result_d = skid_result_q;
          head_flags_d  = skid_flags_q;
          head_cmp_d    = skid_cmp_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_comb begin
    acc_d    = acc_q;
    status_d = status_q;
    err_d    = err_q;
    if (pop) begin
      status_d = head_flags_q;
      if (!head_cmp_q) acc_d = head_result_q;
    end
    // A new invalid op outranks a simultaneous clear.
    if (bad_op)       err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      head_result_q <= '0;
      head_flags_q  <= '0;
      head_cmp_q    <= 1'b0;
      skid_result_q <= '0;
      skid_flags_q  <= '0;
      skid_cmp_q    <= 1'b0;
      acc_q         <= '0;
      status_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      head_result_q <= head_result_d;
      head_flags_q  <= head_flags_d;
      head_cmp_q    <= head_cmp_d;
      skid_result_q <= skid_result_d;
      skid_flags_q  <= skid_flags_d;
      skid_cmp_q    <= skid_cmp_d;
      acc_q         <= acc_d;
      status_q      <= status_d;
      err_q         <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = head_result_q;
  assign out_flags  = head_flags_q;
  assign out_is_cmp = head_cmp_q;
  assign acc        = acc_q;
  assign status     = status_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage: queue-based model
// compared every cycle, plus directed literal checks.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = 3'd0;
  logic [3:0] in_result = 4'd0;
  logic       in_carry = 1'b0;
  logic       in_overflow = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic       out_is_cmp;
  logic [3:0] acc;
  logic [3:0] status;
  logic       err;
  logic       clr_err = 1'b0;

  int errors = 0;
  int checks = 0;

  alu_result_stage #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_is_cmp(out_is_cmp),
    .acc(acc), .status(status), .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic [3:0] f;
    bit         c;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_acc;
  logic [3:0] m_status;
  logic       m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain FIFO of at most two entries; acceptance is decided by occupancy
  // at the start of the cycle, before that cycle's pop.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_acc = 0;
      m_status = 0;
      m_err = 0;
    end else begin
      bit   acc_hs;
      ent_t e;
      acc_hs = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) begin
        e = mq.pop_front();
        m_status = e.f;
        if (!e.c) m_acc = e.r;
      end
      if (acc_hs && in_op <= 3'd4) begin
        e.r = in_result;
        e.f = {in_result >= 4'd8, in_result == 4'd0, in_overflow, in_carry};
        e.c = (in_op == 3'd4);
        mq.push_back(e);
      end
      if (acc_hs && in_op > 3'd4) m_err = 1;
      else if (clr_err)          m_err = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_out_valid", out_valid, mq.size() > 0);
      check("m_in_ready", in_ready, mq.size() < 2);
      check("m_acc", acc, m_acc);
      check("m_status", status, m_status);
      check("m_err", err, m_err);
      if (mq.size() > 0) begin
        check("m_out_result", out_result, mq[0].r);
        check("m_out_flags", out_flags, mq[0].f);
        check("m_out_is_cmp", out_is_cmp, mq[0].c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [3:0] r,
                       input bit c, input bit o);
    in_valid = v; in_op = op; in_result = r; in_carry = c; in_overflow = o;
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 4'd0);
    check("rst_out_flags", out_flags, 4'd0);
    check("rst_acc", acc, 4'd0);
    check("rst_status", status, 4'd0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    step();

    // ADD zero result with carry
    out_ready = 1'b1;
    drive(1, 3'd0, 4'b0000, 1, 0);
    step();
    check("add_valid", out_valid, 1'b1);
    check("add_flags", out_flags, 4'b0101);
    drive(0, 3'd0, 4'd0, 0, 0);
    step();
    check("add_status", status, 4'b0101);
    check("add_acc", acc, 4'd0);

    // SUB then CMP: CMP leaves acc alone
    drive(1, 3'd1, 4'b1001, 1, 1);
    step();
    check("sub_flags", out_flags, 4'b1011);
    drive(1, 3'd4, 4'b0000, 0, 0);
    step();
    check("cmp_is_cmp", out_is_cmp, 1'b1);
    drive(0, 3'd0, 4'd0, 0, 0);
    step();
    check("cmp_acc", acc, 4'b1001);
    check("cmp_status", status, 4'b0100);

    // backpressure: third push held off
    out_ready = 1'b0;
    drive(1, 3'd2, 4'b0011, 0, 0);
    step();
    check("bp_ready1", in_ready, 1'b1);
    drive(1, 3'd3, 4'b0110, 0, 0);
    step();
    check("bp_ready2", in_ready, 1'b0);
    drive(1, 3'd0, 4'b0001, 0, 0);
    step();
    check("bp_held_ready", in_ready, 1'b0);
    check("bp_head0", out_result, 4'b0011);
    out_ready = 1'b1;
    step();
    check("bp_head1", out_result, 4'b0110);
    check("bp_ready3", in_ready, 1'b1);
    step();
    check("bp_head2", out_result, 4'b0001);
    drive(0, 3'd0, 4'd0, 0, 0);
    step();
    check("bp_acc", acc, 4'b0001);
    check("bp_empty", out_valid, 1'b0);

    // streaming in state ONE
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'd0, 4'(i), 0, 0);
      step();
      check("stream_ready", in_ready, 1'b1);
      check("stream_head", out_result, 4'(i));
    end
    drive(0, 3'd0, 4'd0, 0, 0);
    step();
    check("stream_acc", acc, 4'b0111);

    // invalid ops and clear
    out_ready = 1'b0;
    drive(1, 3'b110, 4'd5, 0, 0);
    step();
    check("bad_err", err, 1'b1);
    check("bad_no_entry", out_valid, 1'b0);
    drive(1, 3'b111, 4'd5, 0, 0);
    clr_err = 1'b1;
    step();
    check("bad_set_wins", err, 1'b1);
    drive(0, 3'd0, 4'd0, 0, 0);
    step();
    check("bad_cleared", err, 1'b0);
    clr_err = 1'b0;

    // async reset with two entries buffered
    drive(1, 3'd0, 4'd9, 0, 0);
    step();
    drive(1, 3'd1, 4'd10, 0, 0);
    step();
    drive(0, 3'd0, 4'd0, 0, 0);
    check("pre_rst_ready", in_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_acc", acc, 4'd0);
    check("arst_status", status, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 3'd2, 4'b1100, 1, 0);
    step();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_result", out_result, 4'b1100);
    check("post_rst_flags", out_flags, 4'b1001);
    drive(0, 3'd0, 4'd0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = ($urandom_range(0, 9) == 0) ? 3'(5 + $urandom_range(0, 2))
                                              : 3'($urandom_range(0, 4));
      in_result = 4'($urandom);
      in_carry  = 1'($urandom);
      in_overflow = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err   = ($urandom_range(0, 7) == 0);
      step();
    end
    drive(0, 3'd0, 4'd0, 0, 0);
    out_ready = 1'b1;
    clr_err = 1'b0;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
